// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone-style bus arbiter.
// m0 (instruction fetch) and m1 (data) share one slave. A grant is held
// until the slave acknowledges or the granted master withdraws its strobe,
// and every grant is followed by one IDLE cycle.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin. Without it, m0 always wins a tie.
module wb_arbiter2 #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [XLEN-1:0]     m0_ADR,
    input  logic [XLEN/8-1:0]   m0_SEL,
    input  logic                m0_WE,
    input  logic                m0_STB,
    input  logic [XLEN-1:0]     m0_DAT_W,
    output logic [XLEN-1:0]     m0_DAT_R,
    output logic                m0_ACK,

    input  logic [XLEN-1:0]     m1_ADR,
    input  logic [XLEN/8-1:0]   m1_SEL,
    input  logic                m1_WE,
    input  logic                m1_STB,
    input  logic [XLEN-1:0]     m1_DAT_W,
    output logic [XLEN-1:0]     m1_DAT_R,
    output logic                m1_ACK,

    output logic [XLEN-1:0]     s_ADR,
    output logic [XLEN/8-1:0]   s_SEL,
    output logic                s_WE,
    output logic                s_STB,
    output logic [XLEN-1:0]     s_DAT_W,
    input  logic [XLEN-1:0]     s_DAT_R,
    input  logic                s_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   last_gnt_reg, last_gnt_next;
    logic   tie_pick;   // 0 selects m0, 1 selects m1 when both request in IDLE

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Favour the master that did not complete the most recent transaction.
    assign tie_pick = ~last_gnt_reg;
`else
    // Fixed priority: m0 always wins a tie.
    assign tie_pick = 1'b0;
`endif

    // State register and last-completed-grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Next-state logic: grant on request, release on ack or abort.
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                // An ack seen here is spurious and is ignored.
                if (m0_STB && m1_STB) begin
                    state_next = tie_pick ? GNT1 : GNT0;
                end else if (m0_STB) begin
                    state_next = GNT0;
                end else if (m1_STB) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (s_ACK) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b0;
                end else if (!m0_STB) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (s_ACK) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b1;
                end else if (!m1_STB) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output steering: pass the granted master through. Reset masks
    // everything so a late slave ack cannot leak to a master.
    always_comb begin
        s_ADR   = '0;
        s_SEL   = '0;
        s_WE    = 1'b0;
        s_STB   = 1'b0;
        s_DAT_W = '0;
        m0_ACK  = 1'b0;
        m1_ACK  = 1'b0;
        if (!rst) begin
            case (state_reg)
                GNT0: begin
                    s_ADR   = m0_ADR;
                    s_SEL   = m0_SEL;
                    s_WE    = m0_WE;
                    s_STB   = m0_STB;
                    s_DAT_W = m0_DAT_W;
                    m0_ACK  = s_ACK;
                end
                GNT1: begin
                    s_ADR   = m1_ADR;
                    s_SEL   = m1_SEL;
                    s_WE    = m1_WE;
                    s_STB   = m1_STB;
                    s_DAT_W = m1_DAT_W;
                    m1_ACK  = s_ACK;
                end
                default: ;
            endcase
        end
    end

    // Read data goes to both masters; each qualifies it with its own ack.
    assign m0_DAT_R = s_DAT_R;
    assign m1_DAT_R = s_DAT_R;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2 with an expected-transaction
// scoreboard popped by an ack monitor, plus point checks of timing corners.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] m_adr   [2];
    logic [3:0]  m_sel   [2];
    logic        m_we    [2];
    logic        m_stb   [2];
    logic [31:0] m_dat_w [2];
    logic [31:0] m_dat_r [2];
    logic        m_ack   [2];

    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_we, s_stb, s_ack;

    // Slave model controls.
    logic        slave_en, force_ack;
    logic [3:0]  wait_cfg, wcnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic gap_chk;
    int last_ack_cyc;

    typedef struct {
        int          m;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dw;
        logic [31:0] dr;
    } exp_t;
    exp_t q[$];

    wb_arbiter2 #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_ADR   (m_adr[0]),
        .m0_SEL   (m_sel[0]),
        .m0_WE    (m_we[0]),
        .m0_STB   (m_stb[0]),
        .m0_DAT_W (m_dat_w[0]),
        .m0_DAT_R (m_dat_r[0]),
        .m0_ACK   (m_ack[0]),
        .m1_ADR   (m_adr[1]),
        .m1_SEL   (m_sel[1]),
        .m1_WE    (m_we[1]),
        .m1_STB   (m_stb[1]),
        .m1_DAT_W (m_dat_w[1]),
        .m1_DAT_R (m_dat_r[1]),
        .m1_ACK   (m_ack[1]),
        .s_ADR    (s_adr),
        .s_SEL    (s_sel),
        .s_WE     (s_we),
        .s_STB    (s_stb),
        .s_DAT_W  (s_dat_w),
        .s_DAT_R  (s_dat_r),
        .s_ACK    (s_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: acks after wait_cfg stalled cycles; read data is address-derived.
    always @(posedge clk) begin
        if (!s_stb || s_ack) wcnt <= 4'd0;
        else                 wcnt <= wcnt + 4'd1;
    end
    assign s_ack   = force_ack | (slave_en & s_stb & (wcnt == wait_cfg));
    assign s_dat_r = s_adr ^ 32'hDEADBFEF;

    // Monitor: every master ack must match the next expected transaction.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (m_ack[0] || m_ack[1]) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b adr=%h, required no ack",
                         m_ack[0], m_ack[1], s_adr);
            end else begin
                e  = q.pop_front();
                ok = m_ack[e.m] && !m_ack[1-e.m] && s_stb && (s_adr == e.adr) &&
                     (s_sel == e.sel) && (s_we == e.we) && (s_dat_w == e.dw) &&
                     (m_dat_r[e.m] == e.dr);
                if (!ok) begin
                    miscompares++;
                    $display("FAIL txn: got ack0=%0b ack1=%0b stb=%0b adr=%h sel=%h we=%0b dw=%h dr=%h, required m%0d adr=%h sel=%h we=%0b dw=%h dr=%h",
                             m_ack[0], m_ack[1], s_stb, s_adr, s_sel, s_we, s_dat_w,
                             m_dat_r[e.m], e.m, e.adr, e.sel, e.we, e.dw, e.dr);
                end else begin
                    $display("txn m%0d adr=%h we=%0b dr=%h ok", e.m, e.adr, e.we, e.dr);
                end
            end
            if (gap_chk) begin
                if (last_ack_cyc >= 0) begin
                    vectors++;
                    if (cyc - last_ack_cyc != 2) begin
                        miscompares++;
                        $display("FAIL ack_gap: got %0d cycles, required 2", cyc - last_ack_cyc);
                    end
                end
                last_ack_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    // Present one request and hold it until acked; returns just after the
    // following rising edge so the caller can chain or drop the strobe.
    task automatic issue(input int m, input logic [31:0] adr, input logic [3:0] sel,
                         input logic we, input logic [31:0] dw);
        int n;
        m_adr[m]   = adr;
        m_sel[m]   = sel;
        m_we[m]    = we;
        m_dat_w[m] = dw;
        m_stb[m]   = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (m_ack[m]) break;
            n++;
            if (n > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timeout: m%0d adr=%h got no ack, required ack within 60 cycles", m, adr);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic master_seq(input int m, input logic [31:0] base, input logic we);
        for (int i = 0; i < 4; i++) begin
            issue(m, base + 32'(4 * i), 4'hF, we, we ? 32'(32'hA0 + i) : 32'h0);
        end
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    initial begin
        logic [31:0] dr0 [4];
        logic [31:0] dr1 [4];
        dr0 = '{32'hDEADAFEF, 32'hDEADAFEB, 32'hDEADAFE7, 32'hDEADAFE3};
        dr1 = '{32'hDEAD8FEF, 32'hDEAD8FEB, 32'hDEAD8FE7, 32'hDEAD8FE3};

        rst = 1'b1;
        slave_en = 1'b0; force_ack = 1'b0; wait_cfg = 4'd0;
        gap_chk = 1'b0; last_ack_cyc = -1;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0; m_stb[i] = 1'b0; m_dat_w[i] = '0;
        end

        // Reset state, with m0 already requesting.
        m_stb[0] = 1'b1; m_adr[0] = 32'h55; m_sel[0] = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_s_adr", s_adr, 32'h0);
        chk("rst_m0_ack", 32'(m_ack[0]), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_stb", 32'(s_stb), 32'h0);
        @(negedge clk);
        chk("latency_s_stb", 32'(s_stb), 32'h1);
        chk("latency_s_adr", s_adr, 32'h55);
        m_stb[0] = 1'b0;
        @(posedge clk); #1;

        // Single m0 read, slave acks one cycle after seeing the strobe.
        slave_en = 1'b1; wait_cfg = 4'd1;
        q.push_back('{0, 32'h100, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF});
        issue(0, 32'h100, 4'hF, 1'b0, 32'h0);
        m_stb[0] = 1'b0;
        @(negedge clk);
        chk("t1_idle_s_stb", 32'(s_stb), 32'h0);
        @(posedge clk); #1;

        // Single m1 write.
        wait_cfg = 4'd0;
        q.push_back('{1, 32'h2004, 4'b0011, 1'b1, 32'h1234, 32'hDEAD9FEB});
        issue(1, 32'h2004, 4'b0011, 1'b1, 32'h1234);
        m_stb[1] = 1'b0; m_we[1] = 1'b0;
        @(negedge clk);
        chk("t2_idle_s_stb", 32'(s_stb), 32'h0);
        @(posedge clk); #1;

        // Collision: both masters stream 4 transactions, zero-wait slave.
`ifdef WB_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            q.push_back('{0, 32'h1000 + 32'(4 * i), 4'hF, 1'b0, 32'h0, dr0[i]});
            q.push_back('{1, 32'h3000 + 32'(4 * i), 4'hF, 1'b1, 32'(32'hA0 + i), dr1[i]});
        end
`else
        for (int i = 0; i < 4; i++)
            q.push_back('{0, 32'h1000 + 32'(4 * i), 4'hF, 1'b0, 32'h0, dr0[i]});
        for (int i = 0; i < 4; i++)
            q.push_back('{1, 32'h3000 + 32'(4 * i), 4'hF, 1'b1, 32'(32'hA0 + i), dr1[i]});
`endif
        gap_chk = 1'b1; last_ack_cyc = -1;
        fork
            master_seq(0, 32'h1000, 1'b0);
            master_seq(1, 32'h3000, 1'b1);
        join
        gap_chk = 1'b0;
        @(negedge clk);
        chk("coll_idle_s_stb", 32'(s_stb), 32'h0);
        @(posedge clk); #1;

        // Spurious ack in IDLE is dropped.
        slave_en = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk("spur_m0_ack", 32'(m_ack[0]), 32'h0);
        chk("spur_m1_ack", 32'(m_ack[1]), 32'h0);
        @(posedge clk); #1 force_ack = 1'b0;
        @(negedge clk);
        chk("spur_idle_s_stb", 32'(s_stb), 32'h0);
        @(posedge clk); #1;

        // Abort: m0 granted then withdraws; pending m1 follows after IDLE.
        m_stb[0] = 1'b1; m_adr[0] = 32'h400; m_sel[0] = 4'hF;
        @(posedge clk); #1;
        m_stb[1] = 1'b1; m_adr[1] = 32'h800; m_we[1] = 1'b1; m_dat_w[1] = 32'h77; m_sel[1] = 4'hF;
        @(negedge clk);
        chk("abort_g0_s_stb", 32'(s_stb), 32'h1);
        chk("abort_g0_s_adr", s_adr, 32'h400);
        m_stb[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle_s_stb", 32'(s_stb), 32'h0);
        @(negedge clk);
        chk("abort_g1_s_adr", s_adr, 32'h800);
        chk("abort_g1_s_we", 32'(s_we), 32'h1);
        chk("abort_g1_s_dat_w", s_dat_w, 32'h77);

        // Reset during GNT1 with a simultaneous slave ack.
        @(posedge clk); #1;
        rst = 1'b1; force_ack = 1'b1;
        m_stb[0] = 1'b1; m_adr[0] = 32'h600; m_we[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_m1_ack", 32'(m_ack[1]), 32'h0);
        chk("rst_mid_s_stb", 32'(s_stb), 32'h0);
        @(posedge clk); #1 rst = 1'b0; force_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_after_s_stb", 32'(s_stb), 32'h0);
        @(negedge clk);
        chk("tie_after_rst_s_adr", s_adr, 32'h600);
        chk("tie_after_rst_s_we", 32'(s_we), 32'h0);
        m_stb[0] = 1'b0; m_stb[1] = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
